// File: rtl/cam_axis_pkg.sv
// Shared types and constants for the Camera Link / AXI4-Stream video path.
// Sibling blocks use the Camera Link bit positions; the monitor uses the rest.
package cam_axis_pkg;

    localparam int PIX_W = 24;
    localparam int CNT_W = 16;

    localparam int LVAL_BIT = 24;
    localparam int FVAL_BIT = 25;
    localparam int DVAL_BIT = 26;

    typedef enum logic {
        SEEK,
        FRAME
    } mon_state_e;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic             tuser;
        logic             tlast;
        logic [PIX_W-1:0] tdata;
    } beat_t;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (&v) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/axis_skid_fifo2.sv
// Generic 2-entry AXI4-Stream buffer, one beat per cycle, 1-cycle latency.
// Ready is held low until the first clock edge after reset release.
module axis_skid_fifo2 #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         en_q;
    logic         push;
    logic         pop;

    assign s_ready = en_q & (cnt != 2'd2);
    assign m_valid = (cnt != 2'd0);
    assign m_data  = rd_ptr ? mem1 : mem0;
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0   <= '0;
            mem1   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            en_q   <= 1'b0;
        end else begin
            en_q <= 1'b1;
            if (push) begin
                if (wr_ptr) mem1 <= s_data;
                else        mem0 <= s_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/axis_frame_monitor.sv
// Video pass-through that measures frame geometry on input handshakes
// and raises sticky framing-error flags.
import cam_axis_pkg::*;

module axis_frame_monitor #(
    parameter int EXP_W = 20,
    parameter int EXP_H = 10
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [PIX_W-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    output logic [PIX_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tuser,
    output logic             m_axis_tlast,
    output logic [CNT_W-1:0] frame_width,
    output logic [CNT_W-1:0] frame_height,
    output logic [31:0]      frame_count,
    output logic             frame_done,
    output logic             err_no_sof,
    output logic             err_sof_early,
    output logic             err_line_len,
    output logic             err_frame_size,
    input  logic             err_clear
);

    localparam cnt_t EW = cnt_t'(EXP_W);
    localparam cnt_t EH = cnt_t'(EXP_H);

    beat_t      in_b;
    beat_t      out_b;
    logic       hs;
    mon_state_e state_q;
    mon_state_e state_d;
    cnt_t       pix_q, pix_d;
    cnt_t       line_q, line_d;
    cnt_t       ref_q, ref_d;
    cnt_t       len;
    logic       close;
    logic       set_nosof;
    logic       set_early;
    logic       set_len;
    logic       set_size;

    assign in_b = {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    assign hs   = s_axis_tvalid & s_axis_tready;

    axis_skid_fifo2 #(
        .W($bits(beat_t))
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .s_data  (in_b),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .m_data  (out_b),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign m_axis_tdata = out_b.tdata;
    assign m_axis_tuser = out_b.tuser;
    assign m_axis_tlast = out_b.tlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= SEEK;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (hs && s_axis_tuser) state_d = FRAME;
    end

    // SOF rule first (close + restart), then the EOL rule on the same beat
    always_comb begin
        pix_d     = pix_q;
        line_d    = line_q;
        ref_d     = ref_q;
        len       = '0;
        close     = 1'b0;
        set_nosof = 1'b0;
        set_early = 1'b0;
        set_len   = 1'b0;
        set_size  = 1'b0;
        if (hs) begin
            if (s_axis_tuser) begin
                if (state_q == FRAME) begin
                    close     = 1'b1;
                    set_early = (pix_q != '0);
                    set_size  = (EH != '0) && (line_q != EH);
                end
                pix_d  = '0;
                line_d = '0;
                ref_d  = '0;
            end else if (state_q == SEEK) begin
                set_nosof = 1'b1;
            end
            if (s_axis_tuser || state_q == FRAME) begin
                len   = sat_inc(pix_d);
                pix_d = len;
                if (s_axis_tlast) begin
                    if (line_d == '0) begin
                        ref_d   = len;
                        set_len = (EW != '0) && (len != EW);
                    end else begin
                        set_len = (len != ref_d);
                    end
                    line_d = sat_inc(line_d);
                    pix_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pix_q          <= '0;
            line_q         <= '0;
            ref_q          <= '0;
            frame_width    <= '0;
            frame_height   <= '0;
            frame_count    <= '0;
            frame_done     <= 1'b0;
            err_no_sof     <= 1'b0;
            err_sof_early  <= 1'b0;
            err_line_len   <= 1'b0;
            err_frame_size <= 1'b0;
        end else begin
            pix_q      <= pix_d;
            line_q     <= line_d;
            ref_q      <= ref_d;
            frame_done <= close;
            if (close) begin
                frame_width  <= ref_q;
                frame_height <= line_q;
                frame_count  <= frame_count + 32'd1;
            end
            err_no_sof     <= set_nosof | (err_no_sof & ~err_clear);
            err_sof_early  <= set_early | (err_sof_early & ~err_clear);
            err_line_len   <= set_len | (err_line_len & ~err_clear);
            err_frame_size <= set_size | (err_frame_size & ~err_clear);
        end
    end

endmodule

// File: tb/tb_axis_frame_monitor.sv
// Scoreboard bench for axis_frame_monitor: beat and frame-result queues,
// FIFO occupancy model, and directed framing-error scenarios.
module tb_axis_frame_monitor;
    import cam_axis_pkg::*;

    typedef struct {
        int w;
        int h;
        int c;
    } fexp_t;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic [PIX_W-1:0] s_axis_tdata = '0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic             s_axis_tuser = 1'b0;
    logic             s_axis_tlast = 1'b0;
    logic [PIX_W-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic             m_axis_tuser;
    logic             m_axis_tlast;
    logic [CNT_W-1:0] frame_width;
    logic [CNT_W-1:0] frame_height;
    logic [31:0]      frame_count;
    logic             frame_done;
    logic             err_no_sof;
    logic             err_sof_early;
    logic             err_line_len;
    logic             err_frame_size;
    logic             err_clear = 1'b0;

    int               n_vec = 0;
    int               n_err = 0;
    logic [25:0]      dq[$];
    fexp_t            fq[$];
    bit               mon_en = 1'b0;
    bit               bp = 1'b0;
    int               occ = 0;
    bit               held_v = 1'b0;
    logic [25:0]      held = '0;
    logic [PIX_W-1:0] pix_seq = '0;

    always #5 aclk = ~aclk;

    axis_frame_monitor #(
        .EXP_W(20),
        .EXP_H(10)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tlast   (m_axis_tlast),
        .frame_width    (frame_width),
        .frame_height   (frame_height),
        .frame_count    (frame_count),
        .frame_done     (frame_done),
        .err_no_sof     (err_no_sof),
        .err_sof_early  (err_sof_early),
        .err_line_len   (err_line_len),
        .err_frame_size (err_frame_size),
        .err_clear      (err_clear)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always begin
        @(posedge aclk);
        #1;
        m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // occupancy model, ordering and stall-stability checks
    always @(negedge aclk) begin
        if (mon_en) begin
            chk("s_ready", 32'(s_axis_tready), 32'(occ < 2));
            chk("m_valid", 32'(m_axis_tvalid), 32'(occ != 0));
            if (held_v)
                chk("hold", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, held);
            if (m_axis_tvalid && m_axis_tready) begin
                if (dq.size() == 0)
                    chk("beat_q", dq.size(), 1);
                else
                    chk("data", {m_axis_tuser, m_axis_tlast, m_axis_tdata},
                        dq.pop_front());
            end
            held_v = m_axis_tvalid && !m_axis_tready;
            held   = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
            occ    = occ + int'(s_axis_tvalid && s_axis_tready)
                         - int'(m_axis_tvalid && m_axis_tready);
        end
    end

    always @(negedge aclk) begin
        fexp_t f;
        if (aresetn && frame_done) begin
            if (fq.size() == 0) begin
                chk("done_q", fq.size(), 1);
            end else begin
                f = fq.pop_front();
                chk("width", frame_width, f.w);
                chk("height", frame_height, f.h);
                chk("count", frame_count, f.c);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic send(input logic u, input logic l);
        int t = 0;
        bit ok = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tdata  = pix_seq;
        pix_seq       = pix_seq + 1'b1;
        while (!ok && t < 1000) begin
            @(negedge aclk);
            ok = s_axis_tready;
            if (ok) dq.push_back({u, l, s_axis_tdata});
            @(posedge aclk);
            #1;
            t++;
        end
        if (!ok) chk("send_timeout", t, 0);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int nlines, input int short_idx,
                              input int tail);
        bit first = 1'b1;
        for (int ln = 0; ln < nlines; ln++) begin
            int w = (ln == short_idx) ? 19 : 20;
            for (int p = 0; p < w; p++) begin
                send(first, p == w - 1);
                first = 1'b0;
            end
        end
        for (int p = 0; p < tail; p++) begin
            send(first, 1'b0);
            first = 1'b0;
        end
    endtask

    task automatic push_f(input int w, input int h, input int c);
        fexp_t f;
        f.w = w;
        f.h = h;
        f.c = c;
        fq.push_back(f);
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        idle(1);
        err_clear = 1'b0;
        idle(1);
    endtask

    task automatic do_reset();
        mon_en        = 1'b0;
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            chk("rst_flags", {s_axis_tready, m_axis_tvalid, m_axis_tuser,
                              m_axis_tlast, frame_done, err_no_sof,
                              err_sof_early, err_line_len, err_frame_size}, 0);
            chk("rst_data", m_axis_tdata, 0);
            chk("rst_geom", {frame_width, frame_height}, 0);
            chk("rst_count", frame_count, 0);
            @(posedge aclk);
            #1;
        end
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rdy_pre", s_axis_tready, 0);
        @(posedge aclk);
        #1;
        chk("rdy_post", s_axis_tready, 1);
        dq.delete();
        fq.delete();
        occ    = 0;
        held_v = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        do_reset();

        repeat (5) send(1'b0, 1'b0);
        idle(3);
        chk("no_sof", err_no_sof, 1);
        chk("no_sof_cnt", frame_count, 0);
        chk("no_sof_other", {err_sof_early, err_line_len, err_frame_size}, 0);
        clear_err();
        chk("no_sof_clr", err_no_sof, 0);

        send_frame(10, -1, 0);
        push_f(20, 10, 1);
        send_frame(10, -1, 0);
        push_f(20, 10, 2);
        send_frame(10, -1, 0);
        idle(3);
        chk("nom_cnt", frame_count, 2);
        chk("nom_err", {err_no_sof, err_sof_early, err_line_len,
                        err_frame_size}, 0);

        bp = 1'b1;
        push_f(20, 10, 3);
        send_frame(10, -1, 0);
        push_f(20, 10, 4);
        send_frame(10, -1, 0);
        bp = 1'b0;
        idle(10);
        chk("bp_cnt", frame_count, 4);
        chk("bp_err", {err_no_sof, err_sof_early, err_line_len,
                       err_frame_size}, 0);
        chk("bp_drain", dq.size(), 0);

        push_f(20, 10, 5);
        send_frame(10, 3, 0);
        push_f(20, 10, 6);
        send_frame(10, -1, 0);
        idle(3);
        chk("short_len", err_line_len, 1);
        chk("short_size", err_frame_size, 0);
        chk("short_h", frame_height, 10);
        clear_err();
        chk("short_clr", err_line_len, 0);

        push_f(20, 10, 7);
        send_frame(5, -1, 7);
        push_f(20, 5, 8);
        send_frame(10, -1, 0);
        idle(3);
        chk("early_sof", err_sof_early, 1);
        chk("early_size", err_frame_size, 1);
        chk("early_h", frame_height, 5);
        chk("early_len", err_line_len, 0);
        clear_err();

        push_f(20, 10, 9);
        send_frame(3, -1, 5);
        idle(3);
        chk("pre_rst_q", fq.size(), 0);
        do_reset();
        send_frame(10, -1, 0);
        push_f(20, 10, 1);
        send_frame(1, -1, 0);
        idle(3);
        chk("rst_cnt", frame_count, 1);
        chk("rst_err", {err_no_sof, err_sof_early, err_line_len,
                        err_frame_size}, 0);
        chk("fq_left", fq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_frame_monitor.md
# axis_frame_monitor

Downstream stage placed directly after the Camera Link to AXI4-Stream converter. Passes the 24-bit video stream through a 2-entry buffer unchanged. While doing so it measures the geometry of every frame: pixels per line, lines per frame, and a frame count. It raises sticky error flags for framing violations, such as a missing start-of-frame (SOF), an SOF arriving mid-line, or unequal line lengths, so that software and benches can check the camera path without a frame grabber.

## Interface
- `EXP_W`, default 20: expected pixels per line; 0 disables the width check.
- `EXP_H`, default 10: expected lines per frame; 0 disables the height check.
- `aclk`  in  1  stream clock; all logic is on its rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  24  pixel from the converter.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tready`  out  1  input ready.
- `s_axis_tuser`  in  1  SOF, set on the first pixel of a frame.
- `s_axis_tlast`  in  1  end of line (EOL), set on the last pixel of a line.
- `m_axis_tdata`  out  24  / `m_axis_tvalid` out 1 / `m_axis_tready` in 1 / `m_axis_tuser` out 1 / `m_axis_tlast` out 1: buffered copy of the input.
- `frame_width`  out  16  length of the first line of the last completed frame.
- `frame_height`  out  16  number of complete lines in the last completed frame.
- `frame_count`  out  32  number of completed frames; wraps to 0.
- `frame_done`  out  1  one-cycle pulse when the three registers above update.
- `err_no_sof`  out  1  sticky.
- `err_sof_early`  out  1  sticky.
- `err_line_len`  out  1  sticky.
- `err_frame_size`  out  1  sticky.
- `err_clear`  in  1  synchronous clear of all four sticky flags.

## Operation
- **Data path:** 2-entry FIFO holding the tuple {tdata, tuser, tlast}.
  - `s_axis_tready` is high when the FIFO holds fewer than 2 entries.
  - `m_axis_tvalid` is high when the FIFO is non-empty.
  - No beat is dropped, duplicated or reordered.
- **Monitoring:** acts only on input handshakes (`s_axis_tvalid & s_axis_tready`). Counters are `pix_cnt` (16 bits), `line_cnt` (16 bits) and `ref_w` (16 bits).
- **State `SEEK`** (state after reset):
  - A beat without tuser sets `err_no_sof`; the beat is passed through and not counted.
  - A beat with tuser: go to `FRAME`, `pix_cnt`=1, `line_cnt`=0, `ref_w`=0.
- **State `FRAME`, beat without tuser:**
  - `pix_cnt`++.
  - If tlast is also set: `line_cnt`++, then `pix_cnt`=0.
  - On each tlast, take the line length L (the pixel count including this beat):
    - First line of the frame: `ref_w`=L; if `EXP_W`≠0 and L≠`EXP_W`, set `err_line_len`.
    - Later lines: if L≠`ref_w`, set `err_line_len`.
- **State `FRAME`, beat with tuser:** this closes the previous frame.
  - If `pix_cnt`≠0 (partial line pending), set `err_sof_early`; the partial line is not counted in the height.
  - If `EXP_H`≠0 and `line_cnt`≠`EXP_H`, set `err_frame_size`.
  - Load `frame_width`=`ref_w` and `frame_height`=`line_cnt`, then `frame_count`++ and pulse `frame_done`.
  - Restart counting with this beat as pixel 1 of the new frame; stay in `FRAME`.
- **tuser and tlast on the same beat:** a 1-pixel first line. Apply the SOF rule first, then the EOL rule.
- **Counter saturation:** `pix_cnt` and `line_cnt` saturate at 0xFFFF.
- **Sticky flags:**
  - `err_clear` clears the flags.
  - A set condition in the same cycle as `err_clear` wins; the flag stays 1.

## Timing
- **Reset values:** every output is 0, including `s_axis_tready`, `m_axis_tvalid` and all status outputs. The FIFO is emptied, the state goes to `SEEK` and all counters go to 0.
- **First ready:** `s_axis_tready` rises on the first `aclk` edge after `aresetn` deasserts.
- **Latency:** an input handshake at edge N gives `m_axis_tvalid`=1 with that beat after edge N, i.e. 1 cycle. Sustained throughput is 1 beat per cycle when `m_axis_tready`=1.
- **Output stall:** with `m_axis_tready` low, m_axis outputs hold stable. `s_axis_tready` drops after the second entry is accepted.
- **Status timing:**
  - `frame_done` and the status registers update one cycle after the SOF handshake that closes the frame.
  - Error flags set one cycle after the offending handshake.
- **Reset mid-frame:** the frame in progress is discarded without a `frame_done`; status registers return to 0.

## Structure
- Shared package `cam_axis_pkg`:
  - `PIX_W`=24 and `CNT_W`=16.
  - State enum {`SEEK`, `FRAME`}.
  - Camera Link bit positions: LVAL 24, FVAL 25, DVAL 26, used by sibling blocks.
- Sub-module `axis_skid_fifo2`: the generic 2-entry AXI4-Stream buffer, parameterised on payload width (26 bits here). The geometry logic stays in the top module.

## Test plan
- **Nominal frames:** 3 back-to-back 20x10 frames, `m_axis_tready`=1. Expect:
  - 2 `frame_done` pulses, each with `frame_width`=20, `frame_height`=10; the 3rd frame only closes on a 4th SOF.
  - `frame_count`=2.
  - No errors; output identical to input with 1-cycle latency.
- **Backpressure:** drive `m_axis_tready` with a pseudo-random 50% pattern. Expect:
  - No lost beats and identical ordering.
  - `s_axis_tready` low only while 2 entries are held.
- **Short line:** line 4 of a frame has 19 pixels. Expect `err_line_len`=1 and `frame_height`=10; `err_clear` then returns it to 0.
- **Early SOF:** SOF arrives after 7 pixels of line 6. Expect `err_sof_early`=1, `err_frame_size`=1, `frame_height`=5.
- **No SOF:** 5 beats without tuser after reset. Expect `err_no_sof`=1, beats passed through, `frame_count`=0.
- **Reset mid-frame:** pulse `aresetn` low for 5 cycles mid-frame. Expect:
  - All outputs 0 during reset.
  - `s_axis_tready`=1 one cycle after release.
  - The next complete frame reports 20x10 with `frame_count`=1.
